mem_parity_ctrl: RTL and testbench

//   Request-side controller upstream of the parity memory. Converts a valid/ready

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/parity_chk.sv | 11 +
 rtl/mem_parity_ctrl.sv | 113 +++++++++++
 tb/tb_mem_parity_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the parity memory request controller.
package mem_ctrl_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} ctrl_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/parity_chk.sv
// Splits a {parity,data} memory word and flags an even-parity mismatch.
module parity_chk #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W:0]   word,
  output logic [DATA_W-1:0] data,
  output logic              perr
);
  assign data = word[DATA_W-1:0];
  assign perr = word[DATA_W] ^ (^word[DATA_W-1:0]);
endmodule

// File: rtl/mem_parity_ctrl.sv
// Turns a valid/ready request stream into memory strobes and returns
// parity-checked read responses; counts parity errors with saturation.
module mem_parity_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_perr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W:0]   mem_data_out,
  output logic [ERR_W-1:0]  err_count
);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  ctrl_state_t       state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] chk_data;
  logic              chk_perr;

  parity_chk #(.DATA_W(DATA_W)) u_chk (
    .word (mem_data_out),
    .data (chk_data),
    .perr (chk_perr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_perr    <= 1'b0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mem_address <= req_addr;
            mem_data_in <= req_wdata;
            req_ready   <= 1'b0;
            if (req_we) begin
              mem_write <= 1'b1;
              state     <= WR;
            end else begin
              mem_read <= 1'b1;
              state    <= RD;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WR: begin
          mem_write <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        RD: begin
          mem_read <= 1'b0;
          lat_cnt  <= CNT_W'(RD_LAT - 1);
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          // Counter reaching zero marks the cycle the memory word is valid.
          if (lat_cnt == '0) begin
            rsp_data  <= chk_data;
            rsp_perr  <= chk_perr;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
            if (rsp_perr && (err_count != '1))
              err_count <= err_count + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_parity_ctrl.sv
// Directed bench: DUT0 uses RD_LAT=1/ERR_W=16, DUT1 uses RD_LAT=3/ERR_W=2.
module tb_mem_parity_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [8:0]  mem_data_out = '0;

  logic        rr0, rv0, pe0, mw0, mr0, rr1, rv1, pe1, mw1, mr1;
  logic [7:0]  rd0, di0, rd1, di1;
  logic [15:0] ma0, ma1, ec0;
  logic [1:0]  ec1;

  always #5 clk = ~clk;

  mem_parity_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1), .ERR_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_data(rd0), .rsp_perr(pe0), .mem_write(mw0), .mem_read(mr0),
    .mem_address(ma0), .mem_data_in(di0), .mem_data_out(mem_data_out), .err_count(ec0));

  mem_parity_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LAT(3), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_data(rd1), .rsp_perr(pe1), .mem_write(mw1), .mem_read(mr1),
    .mem_address(ma1), .mem_data_in(di1), .mem_data_out(mem_data_out), .err_count(ec1));

  // Observed view of whichever DUT is under test
  logic        sel = 1'b0;
  logic        o_rr, o_rv, o_pe, o_mw, o_mr;
  logic [7:0]  o_rd, o_di;
  logic [15:0] o_ma, o_ec;
  assign o_rr = sel ? rr1 : rr0;
  assign o_rv = sel ? rv1 : rv0;
  assign o_pe = sel ? pe1 : pe0;
  assign o_mw = sel ? mw1 : mw0;
  assign o_mr = sel ? mr1 : mr0;
  assign o_rd = sel ? rd1 : rd0;
  assign o_di = sel ? di1 : di0;
  assign o_ma = sel ? ma1 : ma0;
  assign o_ec = sel ? {14'b0, ec1} : ec0;

  int total = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (dut%0d, t=%0t)", name, act, exp, sel, $time);
  endtask

  always @(negedge clk) begin
    strobe_excl: assert (!(mw0 && mr0) && !(mw1 && mr1)) else begin
      total++;
      $display("FAIL strobe_overlap: mem_write and mem_read both high at t=%0t", $time);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, o_rr, 0);
    check({tag, "_rsp_valid"}, o_rv, 0);
    check({tag, "_rsp_data"},  o_rd, 0);
    check({tag, "_rsp_perr"},  o_pe, 0);
    check({tag, "_mem_write"}, o_mw, 0);
    check({tag, "_mem_read"},  o_mr, 0);
    check({tag, "_mem_addr"},  o_ma, 0);
    check({tag, "_mem_din"},   o_di, 0);
    check({tag, "_err_count"}, o_ec, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", o_rr, 1);
  endtask

  task automatic send(input mem_req_t r);
    int n = 0;
    @(negedge clk);
    while (!o_rr && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", o_rr, 1);
    req_valid = 1'b1; req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic do_write(input mem_req_t r);
    send(r);
    @(negedge clk);
    check("wr_strobe", o_mw, 1);
    check("wr_addr", o_ma, r.addr);
    check("wr_data", o_di, r.wdata);
    check("wr_busy", {o_rr, o_rv, o_mr}, 0);
    @(negedge clk);
    check("wr_done", {o_rr, o_rv, o_mw}, 3'b100);
  endtask

  task automatic do_read(input mem_req_t r, input logic [8:0] word, input logic [7:0] d,
                         input logic p, input logic [15:0] e, input int hold, input bit q);
    int lat = sel ? 3 : 1;
    logic [8:0] junk = ~word;
    send(r);
    mem_data_out = junk;
    @(negedge clk);
    check("rd_strobe", {o_mr, o_mw, o_rr}, 3'b100);
    check("rd_addr", o_ma, r.addr);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("rd_wait", {o_rv, o_mr}, 0);
    end
    mem_data_out = word;
    @(posedge clk); #1 mem_data_out = junk;
    @(negedge clk);
    check("rsp_valid", o_rv, 1);
    check("rsp_data", o_rd, d);
    check("rsp_perr", o_pe, p);
    if (q) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0BEE; req_wdata = 8'h5A;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", o_rv, 1);
      check("hold_data", {o_rd, o_pe}, {d, p});
      check("hold_blocked", {o_rr, o_mw, o_mr}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_done", {o_rv, o_rr}, 2'b01);
    check("err_count", o_ec, e);
  endtask

  typedef struct {
    mem_req_t   req;
    logic [8:0] word;
    logic [7:0] d;
    logic       p;
    logic [15:0] e;
    int         hold;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic we, input logic [15:0] a, input logic [7:0] wd,
                     input logic [8:0] w, input logic [7:0] d, input logic p,
                     input logic [15:0] e, input int hold);
    vec_t v;
    v.req = '{we: we, addr: a, wdata: wd};
    v.word = w; v.d = d; v.p = p; v.e = e; v.hold = hold;
    vq.push_back(v);
  endtask

  initial begin
    mem_req_t r;
    //  we  addr      wdata  word     data   perr err  hold
    add(1, 16'h1234, 8'hA5, 9'h000, 8'h00, 0, 0, 0);
    add(0, 16'h1234, 8'h00, 9'h0A5, 8'hA5, 0, 0, 0);
    add(0, 16'h1234, 8'h00, 9'h1A5, 8'hA5, 1, 1, 1);
    add(0, 16'h0042, 8'h00, 9'h1FF, 8'hFF, 1, 2, 0);
    add(0, 16'h0043, 8'h00, 9'h03C, 8'h3C, 0, 2, 2);
    add(0, 16'h0044, 8'h00, 9'h107, 8'h07, 0, 2, 0);
    add(1, 16'hFFFF, 8'h00, 9'h000, 8'h00, 0, 0, 0);
    add(0, 16'h0000, 8'h00, 9'h100, 8'h00, 1, 3, 0);

    sel = 1'b0;
    reset_dut();
    // rsp_ready with no response pending must be ignored
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rsp_ready", {o_rv, o_rr, o_ec}, {1'b0, 1'b1, 16'd0});
    rsp_ready = 1'b0;

    foreach (vq[i]) begin
      if (vq[i].req.we) do_write(vq[i].req);
      else do_read(vq[i].req, vq[i].word, vq[i].d, vq[i].p, vq[i].e, vq[i].hold, 1'b0);
    end

    // Backpressure for 5 cycles with a write queued behind the response
    r = '{we: 1'b0, addr: 16'h1234, wdata: 8'h00};
    do_read(r, 9'h0A5, 8'hA5, 1'b0, 16'd3, 5, 1'b1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("queued_wr_strobe", o_mw, 1);
    check("queued_wr_addr", {o_ma, o_di}, {16'h0BEE, 8'h5A});
    @(negedge clk);
    check("queued_wr_done", {o_mw, o_rr}, 2'b01);

    // RD_LAT=3, ERR_W=2: exact latency and saturation
    sel = 1'b1;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      r = '{we: 1'b0, addr: 16'(16'h0100 + i), wdata: 8'h00};
      do_read(r, 9'h1A5, 8'hA5, 1'b1, (i < 3) ? 16'(i + 1) : 16'd3, 0, 1'b0);
    end

    // Reset in RD_WAIT drops the read and clears the error count
    r = '{we: 1'b0, addr: 16'h0777, wdata: 8'h00};
    mem_data_out = 9'h1A5;
    send(r);
    @(negedge clk);
    check("rst_rd_strobe", o_mr, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("rst_rd_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", o_rv, 0);
    end
    check("ready_after_drop", {o_rr, o_ec}, {1'b1, 16'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
